// File: rtl/muxn_pkg.sv
// Shared encodings for the registered N:1 mux: mode values, output-stage
// states and the stall counter width.
package muxn_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   localparam int STALL_W = 16;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found when
// scanning from ptr upward, wrapping modulo N_CH.
module rr_arbiter #(
   parameter int  N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             grant_vld,
   output logic [SEL_W-1:0] grant_idx
);

   always_comb begin
      int j;
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      grant_vld = 1'b0;
      grant_idx = '0;
      j         = 0;
      for (int i = 0; i < N_CH; i++) begin
         j = int'(ptr) + i;
         if (j >= N_CH) j = j - N_CH;
         if (!grant_vld && req[j]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(j);
         end
      end
   end

endmodule

// File: rtl/muxn_rr_reg.sv
// N:1 channel mux with a one-entry registered valid/ready output stage,
// fixed or round-robin selection. Optional stall counter: MUXN_STALL_CNT_EN.
module muxn_rr_reg
   import muxn_pkg::*;
#(
   parameter int  N_CH  = 4,
   parameter int  W     = 8,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH*W-1:0] in_data,
   input  logic [N_CH-1:0]   in_valid,
   output logic [N_CH-1:0]   in_ready,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_ch,
   output logic              out_valid,
   input  logic              out_ready
`ifdef MUXN_STALL_CNT_EN
   ,
   output logic [STALL_W-1:0] stall_cnt
`endif
);

   out_state_e       state_q, state_d;
   logic [SEL_W-1:0] rr_ptr, arb_idx, g_idx;
   logic             arb_vld, fix_vld, g_vld, ld, xfer;
   logic [W-1:0]     g_data;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr),
      .grant_vld (arb_vld),
      .grant_idx (arb_idx)
   );

   always_comb begin
      fix_vld  = 1'b0;
      g_data   = '0;
      in_ready = '0;
      // Compare against each legal index so an out-of-range sel can never index past in_valid.
      for (int k = 0; k < N_CH; k++) begin
         if (sel == SEL_W'(k)) fix_vld = in_valid[k];
      end
      if (mode == MODE_FIXED) begin
         g_vld = fix_vld;
         g_idx = sel;
      end else begin
         g_vld = arb_vld;
         g_idx = arb_idx;
      end
      ld   = (state_q == EMPTY) || out_ready;
      xfer = g_vld && ld && !rst;
      for (int k = 0; k < N_CH; k++) begin
         if (g_idx == SEL_W'(k)) begin
            g_data      = in_data[k*W +: W];
            in_ready[k] = xfer;
         end
      end
      state_d = state_q;
      if (ld) state_d = xfer ? FULL : EMPTY;
   end

   assign out_valid = (state_q == FULL);

   // NOTE: sequential state uses non-blocking assignments only; blocking ones here would race with readers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the data/channel registers are reset too, because the consumer-visible reset value is defined as zero.
         state_q  <= EMPTY;
         out_data <= '0;
         out_ch   <= '0;
         rr_ptr   <= '0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            out_data <= g_data;
            out_ch   <= g_idx;
            if (mode == MODE_RR)
               rr_ptr <= (g_idx == SEL_W'(N_CH-1)) ? '0 : g_idx + 1'b1;
         end
      end
   end

`ifdef MUXN_STALL_CNT_EN
   // Counts back-pressured cycles since the last transfer out; saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (out_valid && out_ready)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != {STALL_W{1'b1}})
         stall_cnt <= stall_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Self-checking bench for muxn_rr_reg: directed tables, multi-cycle corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_muxn_rr_reg;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid, in_ready;
   logic           mode, out_valid, out_ready;
   logic [1:0]     sel, out_ch;
   logic [W-1:0]   out_data;

   logic [3*W-1:0] in_data3;
   logic [2:0]     in_valid3, in_ready3;
   logic           mode3, out_valid3, out_ready3;
   logic [1:0]     sel3, out_ch3;
   logic [W-1:0]   out_data3;

`ifdef MUXN_STALL_CNT_EN
   logic [15:0] stall_cnt, stall_cnt3;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   muxn_rr_reg #(.N_CH(N), .W(W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUXN_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   muxn_rr_reg #(.N_CH(3), .W(W)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
      .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
      .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef MUXN_STALL_CNT_EN
      , .stall_cnt(stall_cnt3)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      #1 rst = 1'b1;
      #1 rst = 1'b0;
   endtask

   typedef struct {
      logic [1:0]   sel;
      logic [W-1:0] exp_data;
      logic [1:0]   exp_ch;
   } fix_vec_t;

   // Behavioural reference: channel scan by modular arithmetic over plain ints.
   int           m_ptr, m_ch, m_stall;
   bit           m_valid;
   logic [W-1:0] m_data;

   function automatic int ref_grant(input logic [N-1:0] iv, input logic md,
                                    input logic [1:0] s, input int ptr);
      if (md == 1'b0) return iv[s] ? int'(s) : -1;
      for (int i = 0; i < N; i++)
         if (iv[(ptr + i) % N]) return (ptr + i) % N;
      return -1;
   endfunction

   initial begin
      fix_vec_t fix_tbl[4];
      int       rr_exp_a[6];
      int       rr_exp_b[4];
      int       g;
      bit       ld;
      logic [N-1:0] exp_rdy;

      fix_tbl[0] = '{2'd0, 8'hA1, 2'd0};
      fix_tbl[1] = '{2'd1, 8'hB2, 2'd1};
      fix_tbl[2] = '{2'd2, 8'hC3, 2'd2};
      fix_tbl[3] = '{2'd3, 8'hD4, 2'd3};
      rr_exp_a = '{0, 1, 2, 3, 0, 1};
      rr_exp_b = '{1, 3, 1, 3};

      rst = 1'b1;
      in_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
      in_valid = 4'hF; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
      in_data3 = {8'hC3, 8'hB2, 8'hA1};
      in_valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd3; out_ready3 = 1'b1;
      repeat (2) tick();

      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_ch",    32'(out_ch),    32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      rst = 1'b0;

      // Fixed mode: sel stepped 0..3, each value lands one edge later.
      mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sel = fix_tbl[i].sel;
         #1 check("fix_in_ready", 32'(in_ready), 32'(4'b0001 << fix_tbl[i].sel));
         tick();
         check("fix_out_data",  32'(out_data),  32'(fix_tbl[i].exp_data));
         check("fix_out_ch",    32'(out_ch),    32'(fix_tbl[i].exp_ch));
         check("fix_out_valid", 32'(out_valid), 32'd1);
      end

      // Asynchronous reset while FULL, between edges.
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_data",  32'(out_data),  32'd0);
      check("arst_out_ch",    32'(out_ch),    32'd0);
      check("arst_in_ready",  32'(in_ready),  32'd0);
      tick();
      rst = 1'b0;

      // Round-robin with all channels valid: no idle cycle, restarts at 0.
      mode = 1'b1; in_valid = 4'hF;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rr_all_ch",    32'(out_ch),    32'(rr_exp_a[i]));
         check("rr_all_valid", 32'(out_valid), 32'd1);
      end
      check("rr_all_data", 32'(out_data), 32'hB2);

      pulse_reset();
      in_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr_1010_ch", 32'(out_ch), 32'(rr_exp_b[i]));
      end

      // Backpressure: hold B2 for five stalled cycles, then drain and refill together.
      mode = 1'b0; sel = 2'd1; in_valid = 4'hF; out_ready = 1'b1;
      tick();
      check("bp_load", 32'(out_data), 32'hB2);
      out_ready = 1'b0; sel = 2'd2;
      for (int i = 0; i < 5; i++) begin
         #1 check("bp_in_ready", 32'(in_ready), 32'd0);
         tick();
         check("bp_hold_data",  32'(out_data),  32'hB2);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
      end
`ifdef MUXN_STALL_CNT_EN
      check("bp_stall_cnt", 32'(stall_cnt), 32'd5);
`endif
      out_ready = 1'b1;
      #1 check("bp_release_rdy", 32'(in_ready), 32'(4'b0100));
      tick();
      check("bp_reload_data",  32'(out_data),  32'hC3);
      check("bp_reload_ch",    32'(out_ch),    32'd2);
      check("bp_reload_valid", 32'(out_valid), 32'd1);
`ifdef MUXN_STALL_CNT_EN
      check("bp_stall_clr", 32'(stall_cnt), 32'd0);
`endif

      // Drain without refill.
      in_valid = 4'h0;
      tick();
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_data",  32'(out_data),  32'hC3);
      check("drain_ch",    32'(out_ch),    32'd2);

      // N_CH=3 instance has had sel=3 with all valid since reset.
      check("oor_in_ready",  32'(in_ready3),  32'd0);
      check("oor_out_valid", 32'(out_valid3), 32'd0);
      check("oor_no_x",      32'($isunknown({out_data3, out_ch3, out_valid3, in_ready3})), 32'd0);
      sel3 = 2'd2;
      tick();
      check("n3_sel2_data", 32'(out_data3), 32'hC3);
      check("n3_sel2_ch",   32'(out_ch3),   32'd2);

      // Randomized traffic against the reference model.
      pulse_reset();
      m_ptr = 0; m_ch = 0; m_stall = 0; m_valid = 1'b0; m_data = '0;
      for (int c = 0; c < 400; c++) begin
         in_data   = $urandom;
         in_valid  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
         mode      = 1'($urandom);
         sel       = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         g  = ref_grant(in_valid, mode, sel, m_ptr);
         ld = !m_valid || out_ready;
         exp_rdy = (g >= 0 && ld) ? 4'(1 << g) : 4'h0;
         #1 check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
         if (m_valid && out_ready) m_stall = 0;
         else if (m_valid && m_stall < 16'hFFFF) m_stall++;
         if (g >= 0 && ld) begin
            m_data  = in_data[g*W +: W];
            m_ch    = g;
            m_valid = 1'b1;
            if (mode) m_ptr = (g + 1) % N;
         end else if (ld) begin
            m_valid = 1'b0;
         end
         tick();
         check("rnd_out_valid", 32'(out_valid), 32'(m_valid));
         check("rnd_out_data",  32'(out_data),  32'(m_data));
         check("rnd_out_ch",    32'(out_ch),    32'(m_ch));
`ifdef MUXN_STALL_CNT_EN
         check("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/muxn_rr_reg.md
Name: muxn_rr_reg

Overview:
- Parametrised successor to the team's 4:1 combinational mux.
- Selects one of N_CH W-bit input channels and presents it through a one-entry registered output stage with a valid/ready handshake.
- Two modes:
  - fixed: external select.
  - round-robin: fair scan over valid channels.
- Sits between multiple producer streams and a single consumer, e.g. a shared UART TX or memory write port.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SEL_W, $clog2(N_CH), width of the select and channel-ID fields (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N_CH*W  packed channel data; channel k occupies bits [k*W+W-1 : k*W].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; combinational, at most one bit high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel selected in fixed mode.
- out_data  output  W  registered output data.
- out_ch  output  SEL_W  channel ID of the data in out_data.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (asynchronous, rst=1):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready all 0 while rst is high.
- Output stage has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Load enable: ld = !out_valid | out_ready. This gives full throughput of one transfer per cycle with no bubble.
- Grant g (combinational, evaluated only when ld=1):
  - Fixed mode: g = sel if sel < N_CH and in_valid[sel]=1; otherwise no grant.
  - Round-robin mode: g = first k with in_valid[k]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_CH; no grant if in_valid is all 0.
- in_ready[g] = ld when a grant exists; all other in_ready bits are 0. A transfer on channel k occurs when in_valid[k] & in_ready[k].
- On a transfer (next edge):
  - out_data <= channel g data.
  - out_ch <= g.
  - out_valid <= 1.
  - In round-robin mode only: rr_ptr <= (g+1) mod N_CH, with wrap at N_CH-1 -> 0.
- FULL with out_ready=1 and no grant: out_valid <= 0; out_data and out_ch hold their last value.
- FULL with out_ready=0: all output registers hold; in_ready all 0.
- Latency: an input accepted at edge t appears on out_data after edge t (one cycle).
- Fixed mode does not modify rr_ptr.
- Mode or sel change takes effect on the next grant evaluation. Data already held in the output register is unaffected.
- sel >= N_CH (non-power-of-2 N_CH): no grant, no X propagation.
- Simultaneous drain and load in the same cycle is legal; the register is replaced and out_valid stays 1.
- in_valid dropping without a handshake is tolerated. The block does not check stream protocol.

Optional Feature:
- Macro MUXN_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (16 bits).
  - Counts cycles where out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
  - Clears synchronously on the first cycle a transfer out occurs (out_valid & out_ready).
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package muxn_pkg holds:
  - the mode encoding constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - the stall counter width constant STALL_W=16.
- Sub-module rr_arbiter (combinational, N_CH-wide): inputs req and ptr, outputs grant_vld and grant_idx.
  - Instantiated once.
  - Reused later by other shared-resource blocks.

Test Plan:
- Reset mid-transfer:
  - Stimulus: with out_valid=1, assert rst asynchronously between edges.
  - Required: out_valid=0, out_data=0, out_ch=0 immediately, without waiting for a clock edge.
  - After release, round-robin restarts at channel 0.
- Fixed mode, N_CH=4, W=8:
  - Stimulus: in_data={8'hD4,8'hC3,8'hB2,8'hA1}, all in_valid=1, out_ready=1, sel stepped 0,1,2,3 one per cycle.
  - Required: out_data sequence A1,B2,C3,D4, each one cycle after its sel; out_ch 0..3.
- Round-robin fairness:
  - Stimulus: mode=1, in_valid=4'b1111 held, out_ready=1.
  - Required: out_ch sequence 0,1,2,3,0,1 with no idle cycle.
  - Stimulus: in_valid=4'b1010.
  - Required: sequence alternates 1,3,1,3.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while FULL holding 8'hB2.
  - Required: out_data stays B2; in_ready=0; with MUXN_STALL_CNT_EN, stall_cnt=5.
  - Stimulus: out_ready=1.
  - Required: next channel loads in the same cycle; stall_cnt clears.
- Drain without refill:
  - Stimulus: FULL, out_ready=1, in_valid=0.
  - Required: out_valid=0 next cycle; out_data retains its last value.
- Out-of-range select:
  - Stimulus: N_CH=3, mode=0, sel=2'd3, all valid.
  - Required: in_ready=0, out_valid stays 0, no X on outputs.
